// File: rtl/add_stream_pkg.sv
// Shared types and defaults for the add stream stage and its reference model.
package add_stream_pkg;

    localparam int ADD_WIDTH = 4;
    localparam int ADD_DEPTH = 4;
    localparam int ADD_CNT_W = 16;

    typedef logic [ADD_WIDTH-1:0] operand_t;
    typedef logic [ADD_WIDTH:0]   sum_t;

    function automatic sum_t add_sum(input operand_t op_a, input operand_t op_b);
        return {1'b0, op_a} + {1'b0, op_b};
    endfunction

endpackage

// File: rtl/add_stream_fifo.sv
// In-order synchronous FIFO with wrap-bit pointers and occupancy output.
// Latency: a push into an empty FIFO is readable at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module add_stream_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_dat,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/add_stream_stage.sv
// Flow-controlled adder: y = a + b (zero-extended), results queued in order.
// Latency: one cycle from accept to out_valid when the queue is empty.
// Backpressure: in_ready depends only on occupancy, never on out_ready.
module add_stream_stage
    import add_stream_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = ADD_DEPTH,
    parameter int CNT_W = ADD_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH:0]           y,
    output logic                     out_carry,
    output logic [CNT_W-1:0]         txn_cnt,
    output logic [CNT_W-1:0]         carry_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] head_dat;
    logic           full;
    logic           empty;
    logic           accept;

    assign sum      = {1'b0, a} + {1'b0, b};
    assign in_ready = !rst && !full;
    assign accept   = in_valid && in_ready;

    add_stream_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (sum),
        .pop      (out_ready),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Head is masked while empty so stale storage never shows on y.
    assign out_valid = !empty;
    assign y         = empty ? '0 : head_dat;
    assign out_carry = y[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt   <= '0;
            carry_cnt <= '0;
        end else if (accept) begin
            if (txn_cnt != '1) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
            if (sum[WIDTH] && (carry_cnt != '1)) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_add_stream_stage.sv
// Directed bench for add_stream_stage, plus a narrow-counter instance for saturation.
module tb_add_stream_stage;
    import add_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_carry;
    logic [3:0]  a, b;
    logic [4:0]  y;
    logic [15:0] txn_cnt, carry_cnt;
    logic [2:0]  level;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_carry;
    logic [3:0]  s_a, s_b;
    logic [4:0]  s_y;
    logic [3:0]  s_txn_cnt, s_carry_cnt;
    logic [2:0]  s_level;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    add_stream_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_carry(out_carry), .txn_cnt(txn_cnt),
        .carry_cnt(carry_cnt), .level(level)
    );

    add_stream_stage #(.WIDTH(4), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(1'b1),
        .y(s_y), .out_carry(s_out_carry), .txn_cnt(s_txn_cnt),
        .carry_cnt(s_carry_cnt), .level(s_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_level", level, 0);
        check("rst_txn", txn_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Back-to-back accepts with a free-running consumer.
        out_ready = 1'b1; in_valid = 1'b1;
        a = 4'd1; b = 4'd3; step();
        check("y_1_3", y, 4);
        check("vld_1_3", out_valid, 1);
        check("txn_after_1", txn_cnt, 1);
        a = 4'd5; b = 4'd6; step();
        check("y_5_6", y, 11);
        a = 4'd7; b = 4'd8; step();
        check("y_7_8", y, 15);
        check("carry_7_8", out_carry, 0);
        in_valid = 1'b0; step();
        check("drained_vld", out_valid, 0);
        check("drained_y", y, 0);
        check("txn_3", txn_cnt, 3);
        check("carry_cnt_0", carry_cnt, 0);

        // Carry-out cases.
        in_valid = 1'b1; a = 4'd15; b = 4'd15; step();
        check("y_15_15", y, 30);
        check("carry_15_15", out_carry, 1);
        check("y_15_15_fn", y, add_sum(4'd15, 4'd15));
        a = 4'd8; b = 4'd8; step();
        check("y_8_8", y, 16);
        check("carry_8_8", out_carry, 1);
        in_valid = 1'b0; step();
        check("carry_cnt_2", carry_cnt, 2);
        check("txn_5", txn_cnt, 5);

        // Fill against a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1;
        a = 4'd1; b = 4'd1; step();
        check("fill_lvl1", level, 1);
        a = 4'd2; b = 4'd2; step();
        a = 4'd3; b = 4'd3; step();
        a = 4'd4; b = 4'd4; step();
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 0);
        a = 4'd5; b = 4'd5; step();
        check("full_ignored_level", level, 4);
        check("full_ignored_txn", txn_cnt, 9);
        check("stall_head_stable", y, 2);
        out_ready = 1'b1; step();
        check("release_y4", y, 4);
        check("release_level", level, 3);
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("release_y6", y, 6);
        check("release_level_pp", level, 3);
        check("fifth_accepted_txn", txn_cnt, 10);
        step();
        check("release_y8", y, 8);
        step();
        check("release_y10", y, 10);
        step();
        check("release_empty", out_valid, 0);

        // Steady push+pop at level 2 across pointer wrap.
        out_ready = 1'b0; in_valid = 1'b1;
        a = 4'd0; b = 4'd1; step();
        a = 4'd1; b = 4'd1; step();
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            a = 4'(i); b = 4'd1;
            check("pp_head", y, 32'(i - 1));
            check("pp_level", level, 2);
            step();
        end
        in_valid = 1'b0;
        check("pp_tail11", y, 11);
        step();
        check("pp_tail12", y, 12);
        step();
        check("pp_drained", out_valid, 0);
        check("pp_txn", txn_cnt, 22);

        // Reset with results buffered.
        out_ready = 1'b0; in_valid = 1'b1;
        a = 4'd9; b = 4'd9; step();
        a = 4'd2; b = 4'd3; step();
        a = 4'd4; b = 4'd4; step();
        in_valid = 1'b0;
        check("pre_rst_level", level, 3);
        rst = 1'b1; step();
        check("mid_rst_in_ready", in_ready, 0);
        rst = 1'b0; #1;
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_y", y, 0);
        check("mid_rst_txn", txn_cnt, 0);
        check("mid_rst_carry_cnt", carry_cnt, 0);
        check("mid_rst_in_ready_back", in_ready, 1);
        out_ready = 1'b1; step(); step();
        check("no_stale_vld", out_valid, 0);

        // Narrow counters saturate.
        s_in_valid = 1'b1; s_a = 4'd8; s_b = 4'd8;
        for (int i = 0; i < 15; i++) step();
        check("sat_txn_15", s_txn_cnt, 15);
        step(); step();
        s_in_valid = 1'b0;
        check("sat_txn_hold", s_txn_cnt, 15);
        check("sat_carry_hold", s_carry_cnt, 15);
        check("sat_y", s_y, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/add_stream_stage.md
Name: add_stream_stage

Overview:
- Registered, flow-controlled adder stage that consumes operand pairs (a, b) from the stimulus side and produces sums y = a + b.
- Sits directly downstream of the operand/stimulus generator and upstream of the checker/scoreboard.
- Results are buffered in a small in-order FIFO, so the producer can run ahead of a stalling consumer.
- Also keeps saturating transaction and carry statistics for end-of-test reporting.

Parameters:
- WIDTH, 4, operand width in bits; sum is WIDTH+1 bits.
- DEPTH, 4, result FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept a pair this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer takes the head this cycle.
- y  output  WIDTH+1  head sum.
- out_carry  output  1  head sum MSB (y[WIDTH]).
- txn_cnt  output  CNT_W  number of accepted pairs.
- carry_cnt  output  CNT_W  number of accepted pairs whose sum carried.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (sampled at posedge, rst=1): pointers, level, txn_cnt and carry_cnt go to 0; out_valid=0; y=0; out_carry=0. in_ready=0 while rst=1 and returns to 1 on the first cycle after rst falls.
- Reset mid-operation flushes all buffered results; nothing is emitted after reset from pre-reset traffic.
- Accept: push when in_valid && in_ready at a posedge. Sum is computed zero-extended: {1'b0,a} + {1'b0,b}, WIDTH+1 bits, never truncated.
- Latency: a pair accepted at edge N is visible with out_valid=1 after edge N if the FIFO was empty (one-cycle latency). Otherwise results leave in acceptance order.
- in_ready = (level < DEPTH). It must not depend combinationally on out_ready; there is no combinational path from input to output.
- Pop: when out_valid && out_ready at a posedge, the head is retired.
- Simultaneous push and pop (only possible while level < DEPTH): level unchanged, both occur.
- Full (level == DEPTH): in_ready=0; an in_valid asserted while full is ignored and not counted.
- Empty: out_valid=0; y and out_carry are forced to 0. out_ready while empty has no effect.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. full/empty are derived from pointer compare; wrap-around across DEPTH is seamless.
- y and out_carry are stable while out_valid=1 and out_ready=0. Producer-side rule: a and b are sampled only on the accept edge.
- Counters:
  - txn_cnt increments on each accept.
  - carry_cnt increments on each accept with sum[WIDTH]=1.
  - Both saturate at all-ones, no wrap.
  - Both update on the edge of acceptance (visible 1 cycle later).

Decomposition:
- Package add_stream_pkg:
  - localparams ADD_WIDTH=4, ADD_DEPTH=4, ADD_CNT_W=16.
  - typedef logic [ADD_WIDTH-1:0] operand_t.
  - typedef logic [ADD_WIDTH:0] sum_t.
  - function add_sum(operand_t, operand_t) returning sum_t, shared with the bench's reference model.
- One sub-module: add_stream_fifo, a parameterised synchronous FIFO (DATA_W, DEPTH, push/pop, level, full/empty).
- The top holds the adder, handshake glue and counters.

Test Plan:
- Reset, then accept pairs (1,3), (5,6), (7,8) on consecutive cycles with out_ready=1 -> y=4, 11, 15 one cycle after each accept; out_carry=0; txn_cnt=3; carry_cnt=0.
- (15,15) and (8,8) accepted -> y=30 with out_carry=1, then y=16 with out_carry=1; carry_cnt=2.
- out_ready=0, push 5 pairs (1,1)…(5,5) -> in_ready drops after the 4th accept, level=4, the 5th pair is not accepted. Release out_ready -> outputs 2, 4, 6, 8 in order, then the 5th pair is accepted and y=10.
- Hold level=2, assert push and pop every cycle for 10 cycles with a=i, b=1 -> level stays 2, outputs in order, pointers wrap past DEPTH without loss.
- Assert rst for one cycle with level=3 -> next cycle out_valid=0, level=0, counters 0, y=0, in_ready=1; no stale result ever appears.
- Preload txn_cnt near saturation (CNT_W=4 variant, 17 accepts) -> txn_cnt holds at 15.
